regpipe_vr: RTL and testbench

- Parametrised elastic pipeline of clock-enabled registers, WIDTH bits wide and DEPTH stages deep.
- Each stage carries a valid bit. Stages advance under a valid/ready handshake, and bubbles collapse so throughput stays at one word per cycle.
- Used wherever a datapath value must be delayed or retimed across DEPTH clocks while tolerating downstream stalls, e.g. display/timer datapaths on the iCEstick.

---
 rtl/regpipe_vr.sv | 92 +++++++++
 tb/tb_regpipe_vr.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regpipe_vr.sv
// rtl/regpipe_vr.sv - elastic valid/ready register pipeline with bubble collapse
module regpipe_vr #(
    parameter int               WIDTH   = 4,
    parameter int               DEPTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
    localparam int OW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] v_nxt;
    logic [DEPTH-1:0] r;
    logic [DEPTH-1:0] up_v;
    logic [DEPTH-1:0] load;
    logic [WIDTH-1:0] d    [DEPTH];
    logic [WIDTH-1:0] up_d [DEPTH];
    logic [OW-1:0]    occ_nxt;

    // Ready ripples from the output back toward the input; an empty stage is always ready.
    always_comb begin
        logic acc;
        acc = out_ready;
        r   = '0;
        for (int s = DEPTH - 1; s >= 0; s--) begin
            acc  = !v[s] || acc;
            r[s] = acc;
        end
    end

    // What each stage sees from upstream: the input port for stage 0, the previous stage otherwise.
    always_comb begin
        up_v = '0;
        for (int s = 0; s < DEPTH; s++) begin
            up_d[s] = RST_VAL;
        end
        up_v[0] = in_valid;
        up_d[0] = in_data;
        for (int s = 1; s < DEPTH; s++) begin
            up_v[s] = v[s-1];
            up_d[s] = d[s-1];
        end
    end

    // Next valid vector, data-load enables, and the popcount that becomes the registered occupancy.
    always_comb begin
        occ_nxt = '0;
        load    = '0;
        v_nxt   = v;
        for (int s = 0; s < DEPTH; s++) begin
            load[s]  = r[s] && up_v[s];
            v_nxt[s] = r[s] ? up_v[s] : v[s];
            occ_nxt  = occ_nxt + OW'(v_nxt[s]);
        end
    end

    // Stage registers: reset wins over flush; data only loads when a valid word moves in.
    always_ff @(posedge clk) begin
        if (rst) begin
            v         <= '0;
            occupancy <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                d[s] <= RST_VAL;
            end
        end else if (flush) begin
            v         <= '0;
            occupancy <= '0;
        end else begin
            v         <= v_nxt;
            occupancy <= occ_nxt;
            for (int s = 0; s < DEPTH; s++) begin
                if (load[s]) begin
                    d[s] <= up_d[s];
                end
            end
        end
    end

    assign in_ready  = r[0] && !flush;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

endmodule

// File: tb/tb_regpipe_vr.sv
// tb/tb_regpipe_vr.sv - self-checking bench for regpipe_vr (default and WIDTH=8/DEPTH=1 builds)
module tb_regpipe_vr;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, flush, in_valid, out_ready;
    logic [3:0] in_data;
    logic       in_ready, out_valid;
    logic [3:0] out_data;
    logic [1:0] occupancy;

    logic       b_flush, b_in_valid, b_out_ready;
    logic [7:0] b_in_data;
    logic       b_in_ready, b_out_valid;
    logic [7:0] b_out_data;
    logic [0:0] b_occupancy;

    int checks = 0;
    int failures = 0;
    logic [3:0] qa[$];
    logic [7:0] qb[$];
    logic [3:0] ea;
    logic [7:0] eb;

    regpipe_vr #(.WIDTH(4), .DEPTH(3), .RST_VAL(4'h0)) dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );

    regpipe_vr #(.WIDTH(8), .DEPTH(1), .RST_VAL(8'hFF)) dut_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .occupancy(b_occupancy)
    );

    // Scoreboard for instance A: push on accepted input, pop and compare on output transfer.
    always @(negedge clk) begin
        #3;
        if (rst) begin
            qa.delete();
        end else begin
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (qa.size() == 0) begin
                    failures++;
                    $display("FAIL a_scoreboard got=%h want=no_output", out_data);
                end else begin
                    ea = qa.pop_front();
                    if (out_data !== ea) begin
                        failures++;
                        $display("FAIL a_scoreboard got=%h want=%h", out_data, ea);
                    end
                end
            end
            if (flush) qa.delete();
            if (in_valid && in_ready === 1'b1) qa.push_back(in_data);
        end
    end

    // Scoreboard for instance B.
    always @(negedge clk) begin
        #3;
        if (rst) begin
            qb.delete();
        end else begin
            if (b_out_valid === 1'b1 && b_out_ready) begin
                checks++;
                if (qb.size() == 0) begin
                    failures++;
                    $display("FAIL b_scoreboard got=%h want=no_output", b_out_data);
                end else begin
                    eb = qb.pop_front();
                    if (b_out_data !== eb) begin
                        failures++;
                        $display("FAIL b_scoreboard got=%h want=%h", b_out_data, eb);
                    end
                end
            end
            if (b_flush) qb.delete();
            if (b_in_valid && b_in_ready === 1'b1) qb.push_back(b_in_data);
        end
    end

    task automatic randomize_inputs();
        flush       = 1'($urandom);
        in_valid    = 1'($urandom);
        in_data     = 4'($urandom);
        out_ready   = 1'($urandom);
        b_flush     = 1'($urandom);
        b_in_valid  = 1'($urandom);
        b_in_data   = 8'($urandom);
        b_out_ready = 1'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        randomize_inputs();
        @(negedge clk);
        randomize_inputs();
        @(negedge clk);
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b0;
        b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = 8'h00; b_out_ready = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (out_data !== 4'h0) begin failures++; $display("FAIL reset_out_data got=%h want=0", out_data); end
        checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL reset_occupancy got=%0d want=0", occupancy); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++; if (b_out_valid !== 1'b0) begin failures++; $display("FAIL reset_b_out_valid got=%b want=0", b_out_valid); end
        checks++; if (b_out_data !== 8'hFF) begin failures++; $display("FAIL reset_b_out_data got=%h want=ff", b_out_data); end
        checks++; if (b_occupancy !== 1'b0) begin failures++; $display("FAIL reset_b_occupancy got=%0d want=0", b_occupancy); end
        checks++; if (b_in_ready !== 1'b1) begin failures++; $display("FAIL reset_b_in_ready got=%b want=1", b_in_ready); end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (i < 3);
            in_data   = 4'(i + 1);
            #1;
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready i=%0d got=%b want=1", i, in_ready); end
            if (i >= 3 && i <= 5) begin
                checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stream_out_valid i=%0d got=%b want=1", i, out_valid); end
                checks++; if (out_data !== 4'(i - 2)) begin failures++; $display("FAIL stream_out_data i=%0d got=%h want=%h", i, out_data, 4'(i - 2)); end
            end
            if (i == 3) begin
                checks++; if (occupancy !== 2'd3) begin failures++; $display("FAIL stream_occupancy got=%0d want=3", occupancy); end
            end
            if (i == 6) begin
                checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_drained got=%b want=0", out_valid); end
            end
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            out_ready = (i >= 5);
            in_valid  = (i <= 5);
            in_data   = (i < 3) ? 4'hA + 4'(i) : 4'hD;
            #1;
            if (i < 3) begin
                checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_accept i=%0d got=%b want=1", i, in_ready); end
            end
            if (i == 3 || i == 4) begin
                checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_stall_in_ready i=%0d got=%b want=0", i, in_ready); end
                checks++; if (occupancy !== 2'd3) begin failures++; $display("FAIL bp_full_occupancy i=%0d got=%0d want=3", i, occupancy); end
            end
            if (i == 5) begin
                checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_full_pop_in_ready got=%b want=1", in_ready); end
            end
            if (i >= 5 && i <= 8) begin
                checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid i=%0d got=%b want=1", i, out_valid); end
                checks++; if (out_data !== 4'hA + 4'(i - 5)) begin failures++; $display("FAIL bp_order i=%0d got=%h want=%h", i, out_data, 4'hA + 4'(i - 5)); end
            end
            if (i == 6) begin
                checks++; if (occupancy !== 2'd3) begin failures++; $display("FAIL bp_push_pop_occupancy got=%0d want=3", occupancy); end
            end
            if (i == 9) begin
                checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin failures++; $display("FAIL bp_empty got=%b/%0d want=0/0", out_valid, occupancy); end
            end
        end
    endtask

    task automatic test_bubble();
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            out_ready = (i >= 7);
            in_valid  = (i == 0) || (i >= 4 && i <= 6);
            in_data   = (i == 0) ? 4'h5 : 4'(i + 2);
            #1;
            if (i <= 5) begin
                checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bubble_in_ready i=%0d got=%b want=1", i, in_ready); end
            end
            if (i == 3) begin
                checks++; if (out_valid !== 1'b1 || out_data !== 4'h5) begin failures++; $display("FAIL bubble_arrival got=%b/%h want=1/5", out_valid, out_data); end
                checks++; if (occupancy !== 2'd1) begin failures++; $display("FAIL bubble_occupancy got=%0d want=1", occupancy); end
            end
            if (i == 6) begin
                checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bubble_full_in_ready got=%b want=0", in_ready); end
                checks++; if (occupancy !== 2'd3) begin failures++; $display("FAIL bubble_full_occupancy got=%0d want=3", occupancy); end
            end
            if (i >= 7 && i <= 9) begin
                checks++; if (out_valid !== 1'b1 || out_data !== 4'(i - 2)) begin failures++; $display("FAIL bubble_drain i=%0d got=%b/%h want=1/%h", i, out_valid, out_data, 4'(i - 2)); end
            end
            if (i == 10) begin
                checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bubble_empty got=%b want=0", out_valid); end
            end
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            flush     = (i == 2);
            out_ready = (i >= 3);
            in_valid  = (i <= 3);
            in_data   = (i == 0) ? 4'h9 : (i == 1) ? 4'hE : (i == 2) ? 4'h7 : 4'h8;
            #1;
            if (i == 2) begin
                checks++; if (occupancy !== 2'd2) begin failures++; $display("FAIL flush_pre_occupancy got=%0d want=2", occupancy); end
                checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%b want=0", in_ready); end
            end
            if (i == 3) begin
                checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL flush_occupancy got=%0d want=0", occupancy); end
                checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%b want=0", out_valid); end
                checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_post_in_ready got=%b want=1", in_ready); end
            end
            if (i == 4 || i == 5 || i == 7) begin
                checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_latency i=%0d got=%b want=0", i, out_valid); end
            end
            if (i == 6) begin
                checks++; if (out_valid !== 1'b1 || out_data !== 4'h8) begin failures++; $display("FAIL flush_next_word got=%b/%h want=1/8", out_valid, out_data); end
            end
        end
        flush = 1'b0;
    endtask

    task automatic test_b_stream();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            b_out_ready = 1'b1;
            b_in_valid  = (i < 3);
            b_in_data   = 8'hF0 + 8'(i);
            #1;
            checks++; if (b_in_ready !== 1'b1) begin failures++; $display("FAIL b_stream_in_ready i=%0d got=%b want=1", i, b_in_ready); end
            if (i >= 1 && i <= 3) begin
                checks++; if (b_out_valid !== 1'b1 || b_out_data !== 8'hF0 + 8'(i - 1)) begin failures++; $display("FAIL b_stream_out i=%0d got=%b/%h want=1/%h", i, b_out_valid, b_out_data, 8'hF0 + 8'(i - 1)); end
                checks++; if (b_occupancy !== 1'b1) begin failures++; $display("FAIL b_stream_occupancy i=%0d got=%0d want=1", i, b_occupancy); end
            end
            if (i == 4) begin
                checks++; if (b_out_valid !== 1'b0) begin failures++; $display("FAIL b_stream_empty got=%b want=0", b_out_valid); end
            end
        end
        b_in_valid = 1'b0;
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            out_ready   = (i >= 4);
            rst         = (i == 3);
            in_valid    = (i <= 3);
            in_data     = 4'(i + 1);
            b_out_ready = (i >= 4);
            b_in_valid  = (i <= 3);
            b_in_data   = 8'h3C + 8'(i);
            #1;
            if (i == 3) begin
                checks++; if (occupancy !== 2'd3) begin failures++; $display("FAIL rstmid_full got=%0d want=3", occupancy); end
                checks++; if (b_out_valid !== 1'b1 || b_in_ready !== 1'b0) begin failures++; $display("FAIL rstmid_b_full got=%b/%b want=1/0", b_out_valid, b_in_ready); end
            end
            if (i == 4) begin
                checks++; if (occupancy !== 2'd0 || out_data !== 4'h0 || in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_a_state got=%0d/%h/%b want=0/0/1", occupancy, out_data, in_ready); end
                checks++; if (b_occupancy !== 1'b0 || b_out_data !== 8'hFF || b_in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_b_state got=%0d/%h/%b want=0/ff/1", b_occupancy, b_out_data, b_in_ready); end
            end
            if (i >= 4) begin
                checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_a_stale i=%0d got=%b want=0", i, out_valid); end
                checks++; if (b_out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_b_stale i=%0d got=%b want=0", i, b_out_valid); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_bubble();
        test_flush();
        test_b_stream();
        test_reset_midstream();
        @(negedge clk);
        #5;
        checks++; if (qa.size() != 0) begin failures++; $display("FAIL a_leftover got=%0d want=0", qa.size()); end
        checks++; if (qb.size() != 0) begin failures++; $display("FAIL b_leftover got=%0d want=0", qb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
